proc_ctrl_seq: RTL
==================

Name: proc_ctrl_seq

Overview:
- Multi-cycle control sequencer for the 10-bit processor datapath: register file R0–R7, accumulator A, ALU result register G, external data input, one shared 10-bit bus.
- Latches a 10-bit instruction when EXEC is asserted.
- Steps through timesteps T0–T3, driving one-hot register in/out enables, bus-source selects, ALU op and DONE.
- Sits between the instruction source (switches/memory) and the datapath registers. It owns bus arbitration: at most one bus driver is enabled per cycle.

Parameters:
- DATA_W, 10, instruction/IR width (fixed encoding below requires 10)
- NREG, 8, number of general registers (register fields are 3 bits)

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous reset, active-high
- EXEC  in  1  start request; sampled only in T0
- INSTR  in  DATA_W  instruction word: [9:6] opcode, [5:3] Rx (destination), [2:0] Ry (source)
- IR_Q  out  DATA_W  latched instruction
- TSTEP  out  2  current timestep (0..3)
- BUSY  out  1  high when TSTEP != 0
- RIN  out  NREG  one-hot register load enable
- ROUT  out  NREG  one-hot register bus drive enable
- EXT_OUT  out  1  external data drives bus
- A_EN  out  1  load accumulator A from bus
- G_EN  out  1  load G from ALU
- G_OUT  out  1  G drives bus
- ALU_OP  out  2  00 add, 01 sub, 10 invert (~bus), 11 pass
- DONE  out  1  one-cycle pulse in the final step of an instruction

Behaviour:
- State is a 2-bit timestep counter plus the IR register, both updated on rising CLK.
- All control outputs are combinational decodes of the registered TSTEP and IR_Q only. There is no combinational path from EXEC or INSTR to any output.
- Reset (RST=1 at a rising edge): TSTEP=0, IR_Q=0. Every output is deasserted and ALU_OP=00 for as long as TSTEP=0.
  - Reset mid-instruction aborts it. No DONE is produced and no RIN fires after the reset edge.
- T0 (idle):
  - Outputs all zero.
  - If EXEC=1: IR_Q<=INSTR and TSTEP<=1. Otherwise hold.
  - EXEC while BUSY=1 is ignored (no queuing). INSTR changes while BUSY have no effect.
- Per-opcode sequences (Rx = IR_Q[5:3], Ry = IR_Q[2:0]):
  - 0000 LOAD, 1 step. T1: EXT_OUT, RIN[Rx], DONE.
  - 0001 MOV, 1 step. T1: ROUT[Ry], RIN[Rx], DONE.
  - 0010 ADD / 0011 SUB, 3 steps.
    - T1: ROUT[Rx], A_EN.
    - T2: ROUT[Ry], G_EN, ALU_OP = 00 (ADD) or 01 (SUB).
    - T3: G_OUT, RIN[Rx], DONE.
  - 0100 INV, 2 steps.
    - T1: ROUT[Ry], G_EN, ALU_OP=10.
    - T2: G_OUT, RIN[Rx], DONE.
  - 0101–1111 reserved: T1 DONE only, no enables (NOP).
- On the rising edge following a DONE cycle, TSTEP<=0. Otherwise TSTEP increments by 1. TSTEP never wraps 3→0 except via DONE.
- Bus rule: in every cycle, popcount(ROUT) + EXT_OUT + G_OUT ≤ 1.
- ALU_OP is 00 in every cycle where G_EN=0.
- RIN and ROUT are each always zero or one-hot.
- Rx=Ry is legal. For example, MOV R3,R3 gives ROUT[3] and RIN[3] in the same cycle.
- Back-to-back instructions: EXEC held high across DONE starts the next instruction in the T0 cycle that follows DONE. Minimum issue interval is instruction length + 1 cycle.
- Instruction latency from the EXEC-sampled edge to DONE: 1 cycle for LOAD/MOV/reserved, 2 for INV, 3 for ADD/SUB.

Test Plan:
- Reset: assert RST for 2 cycles with EXEC=1, INSTR=0x0C5 → TSTEP=0, IR_Q=0x000, all enables 0, DONE never asserts.
- LOAD R2: INSTR=0x010 (opcode 0000, Rx=2), EXEC pulse → next cycle EXT_OUT=1, RIN=0x04, DONE=1; following cycle TSTEP=0, BUSY=0.
- ADD R1,R5: INSTR=0x08D, EXEC → T1 ROUT=0x02, A_EN=1; T2 ROUT=0x20, G_EN=1, ALU_OP=00; T3 G_OUT=1, RIN=0x02, DONE=1.
  - Checker asserts the bus-driver ≤1 rule every cycle.
- SUB then INV with EXEC held high: 0x0CA followed by 0x100 → SUB completes in 3 steps (ALU_OP=01 in T2). T0 follows with IR_Q←0x100. INV runs T1 (ROUT=0x01, ALU_OP=10), then T2 (RIN=0x01, DONE).
  - Mid-instruction INSTR changes are ignored.
- Reserved and abort: INSTR=0x3FF, EXEC → T1 DONE only, no enables. Then start ADD 0x08D and assert RST during T2 → next cycle TSTEP=0, no RIN, no DONE.
- MOV R3,R3: INSTR=0x05B, EXEC → T1 ROUT=0x08, RIN=0x08, DONE=1; EXEC re-asserted during BUSY does not restart the sequence.

Source files
------------

// File: rtl/proc_ctrl_seq.sv
// ---------------------------------------------------------------------------
// proc_ctrl_seq
// Multi-cycle control sequencer for a 10-bit processor datapath. The datapath
// has R0..R7, accumulator A, ALU result register G, an external data input and
// a single shared bus.
//
// The block latches an instruction when EXEC is seen in idle (T0). It then
// walks timesteps T1..T3 and drives the register/bus/ALU controls for that
// instruction. All control outputs decode only the registered timestep and
// instruction, so neither EXEC nor INSTR has a combinational path to them.
//
// Ports
//   CLK      in   rising-edge clock
//   RST      in   synchronous reset, active-high
//   EXEC     in   start request, sampled only in T0
//   INSTR    in   [9:6] opcode, [5:3] Rx (destination), [2:0] Ry (source)
//   IR_Q     out  latched instruction
//   TSTEP    out  current timestep 0..3
//   BUSY     out  TSTEP != 0
//   RIN      out  one-hot register load enable
//   ROUT     out  one-hot register bus drive enable
//   EXT_OUT  out  external data drives bus
//   A_EN     out  load A from bus
//   G_EN     out  load G from ALU
//   G_OUT    out  G drives bus
//   ALU_OP   out  00 add, 01 sub, 10 invert, 11 pass
//   DONE     out  one-cycle pulse in the final step of an instruction
// ---------------------------------------------------------------------------
module proc_ctrl_seq #(
  parameter int DATA_W = 10,
  parameter int NREG   = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EXEC,
  input  logic [DATA_W-1:0] INSTR,
  output logic [DATA_W-1:0] IR_Q,
  output logic [1:0]        TSTEP,
  output logic              BUSY,
  output logic [NREG-1:0]   RIN,
  output logic [NREG-1:0]   ROUT,
  output logic              EXT_OUT,
  output logic              A_EN,
  output logic              G_EN,
  output logic              G_OUT,
  output logic [1:0]        ALU_OP,
  output logic              DONE
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_e;

  localparam logic [3:0] OP_LOAD = 4'b0000;
  localparam logic [3:0] OP_MOV  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_INV  = 4'b0100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_INV = 2'b10;

  tstep_e            tstep_q, tstep_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [3:0]        opcode_s;
  logic [2:0]        rx_s;
  logic [2:0]        ry_s;

  // Decode a 3-bit register field into a one-hot enable vector.
  function automatic logic [NREG-1:0] onehot(input logic [2:0] idx);
    logic [NREG-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign opcode_s = ir_q[9:6];
  assign rx_s     = ir_q[5:3];
  assign ry_s     = ir_q[2:0];

  assign IR_Q  = ir_q;
  assign TSTEP = tstep_q;
  assign BUSY  = (tstep_q != T0);

  // Control decode from registered timestep and instruction only.
  always_comb begin
    RIN     = '0;
    ROUT    = '0;
    EXT_OUT = 1'b0;
    A_EN    = 1'b0;
    G_EN    = 1'b0;
    G_OUT   = 1'b0;
    ALU_OP  = ALU_ADD;
    DONE    = 1'b0;
    case (tstep_q)
      T0: begin
        // Idle: everything stays deasserted.
      end
      T1: begin
        case (opcode_s)
          OP_LOAD: begin
            EXT_OUT = 1'b1;
            RIN     = onehot(rx_s);
            DONE    = 1'b1;
          end
          OP_MOV: begin
            ROUT = onehot(ry_s);
            RIN  = onehot(rx_s);
            DONE = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ROUT = onehot(rx_s);
            A_EN = 1'b1;
          end
          OP_INV: begin
            ROUT   = onehot(ry_s);
            G_EN   = 1'b1;
            ALU_OP = ALU_INV;
          end
          default: begin
            // Reserved opcodes complete as a NOP.
            DONE = 1'b1;
          end
        endcase
      end
      T2: begin
        case (opcode_s)
          OP_ADD, OP_SUB: begin
            ROUT   = onehot(ry_s);
            G_EN   = 1'b1;
            ALU_OP = (opcode_s == OP_SUB) ? ALU_SUB : ALU_ADD;
          end
          OP_INV: begin
            G_OUT = 1'b1;
            RIN   = onehot(rx_s);
            DONE  = 1'b1;
          end
          default: begin
            // Other opcodes finish in T1 and never reach T2.
          end
        endcase
      end
      T3: begin
        case (opcode_s)
          OP_ADD, OP_SUB: begin
            G_OUT = 1'b1;
            RIN   = onehot(rx_s);
            DONE  = 1'b1;
          end
          default: begin
            // Only ADD/SUB reach T3.
          end
        endcase
      end
      default: begin
      end
    endcase
  end

  // Next-state: latch on EXEC in idle, advance while busy, return to idle after DONE.
  always_comb begin
    tstep_d = tstep_q;
    ir_d    = ir_q;
    case (tstep_q)
      T0: begin
        if (EXEC) begin
          ir_d    = INSTR;
          tstep_d = T1;
        end else begin
          tstep_d = T0;
        end
      end
      T1, T2: begin
        if (DONE) begin
          tstep_d = T0;
        end else begin
          tstep_d = tstep_e'(tstep_q + 2'd1);
        end
      end
      T3: begin
        // T3 is always a final step; never advance past it.
        tstep_d = T0;
      end
      default: begin
        tstep_d = T0;
      end
    endcase
  end

  // Timestep and instruction registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tstep_q <= T0;
      ir_q    <= '0;
    end else begin
      tstep_q <= tstep_d;
      ir_q    <= ir_d;
    end
  end

endmodule
